// File: rtl/truth_table_checker.sv
// Steps an external 4-input circuit through all 16 vectors and compares
// its sampled output G against a golden truth table.
`timescale 1ns/1ps
module truth_table_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        vec_valid,
    input  logic [3:0]  vec,
    output logic        vec_ready,
    input  logic        g_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        seq_err,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        first_fail_vld,
    output logic [15:0] captured
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_VEC    = 2'd1;
    localparam logic [1:0] SETTLE_WAIT = 2'd2;
    localparam logic [1:0] DONE        = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       miss;

    assign miss = g_in ^ EXPECTED[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 4'd0;
            cnt            <= 4'd0;
            vec_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            seq_err        <= 1'b0;
            mismatch_cnt   <= 5'd0;
            first_fail     <= 4'd0;
            first_fail_vld <= 1'b0;
            captured       <= 16'h0000;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= WAIT_VEC;
                        idx            <= 4'd0;
                        cnt            <= 4'd0;
                        vec_ready      <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        seq_err        <= 1'b0;
                        mismatch_cnt   <= 5'd0;
                        first_fail     <= 4'd0;
                        first_fail_vld <= 1'b0;
                        captured       <= 16'h0000;
                    end
                end
                WAIT_VEC: begin
                    if (vec_valid) begin
                        vec_ready <= 1'b0;
                        if (vec == idx) begin
                            state <= SETTLE_WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state   <= DONE;
                            seq_err <= 1'b1;
                            pass    <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                SETTLE_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        captured[idx] <= g_in;
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt + 5'd1;
                            if (!first_fail_vld) begin
                                first_fail     <= idx;
                                first_fail_vld <= 1'b1;
                            end
                        end
                        // the last vector's own comparison must count toward pass
                        if (idx == 4'd15) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (mismatch_cnt == 5'd0) && !miss;
                        end else begin
                            idx       <= idx + 4'd1;
                            state     <= WAIT_VEC;
                            vec_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized bench for truth_table_checker with an in-bench
// transaction-level reference model.
`timescale 1ns/1ps
module tb_truth_table_checker;

    localparam logic [15:0] EXP_A  = 16'hA5C3;
    localparam int          SETT_A = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, vec_valid, g_in;
    logic [3:0]  vec;
    logic        vec_ready, busy, done, pass, seq_err, first_fail_vld;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic [15:0] captured;
    logic [15:0] tab;

    logic        b_start, b_vv, b_g;
    logic [3:0]  b_vec;
    logic        b_ready, b_busy, b_done, b_pass, b_seq, b_ffv;
    logic [4:0]  b_mis;
    logic [3:0]  b_ff;
    logic [15:0] b_cap;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit          m_run, m_done, m_seq, m_pass, m_ffv;
    logic [3:0]  m_idx, m_ff;
    int          m_left, m_mis;
    logic [15:0] m_cap;

    always #5 clk = ~clk;

    // the circuit under test: a pure lookup of the applied vector
    assign g_in = tab[vec];

    truth_table_checker #(.EXPECTED(EXP_A), .SETTLE(SETT_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .vec(vec), .vec_ready(vec_ready), .g_in(g_in), .busy(busy),
        .done(done), .pass(pass), .seq_err(seq_err),
        .mismatch_cnt(mismatch_cnt), .first_fail(first_fail),
        .first_fail_vld(first_fail_vld), .captured(captured)
    );

    truth_table_checker #(.EXPECTED(EXP_A), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .vec_valid(b_vv),
        .vec(b_vec), .vec_ready(b_ready), .g_in(b_g), .busy(b_busy),
        .done(b_done), .pass(b_pass), .seq_err(b_seq),
        .mismatch_cnt(b_mis), .first_fail(b_ff),
        .first_fail_vld(b_ffv), .captured(b_cap)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 60)
                $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_seq = 0; m_pass = 0; m_ffv = 0;
        m_idx = 0; m_ff = 0; m_left = 0; m_mis = 0; m_cap = 16'h0;
    endtask

    // one clock edge of the checker's behaviour, from inputs seen at the edge
    task automatic model_edge();
        if (!rst_n) return;
        if (start && !m_run) begin
            model_reset();
            m_run = 1;
        end else if (m_run && m_left == 0) begin
            if (vec_valid) begin
                if (vec == m_idx) m_left = SETT_A;
                else begin
                    m_seq = 1; m_pass = 0; m_done = 1; m_run = 0;
                end
            end
        end else if (m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_cap[m_idx] = g_in;
                if (g_in != EXP_A[m_idx]) begin
                    m_mis++;
                    if (!m_ffv) begin m_ffv = 1; m_ff = m_idx; end
                end
                if (m_idx == 4'd15) begin
                    m_run = 0; m_done = 1; m_pass = (m_mis == 0);
                end else m_idx = m_idx + 4'd1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("vec_ready", 32'(vec_ready), 32'(m_run && m_left == 0));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("seq_err", 32'(seq_err), 32'(m_seq));
            chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
            chk("first_fail", 32'(first_fail), 32'(m_ff));
            chk("first_fail_vld", 32'(first_fail_vld), 32'(m_ffv));
            chk("captured", 32'(captured), 32'(m_cap));
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_vec_ready"}, 32'(vec_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_seq_err"}, 32'(seq_err), 0);
        chk({tag, "_mis"}, 32'(mismatch_cnt), 0);
        chk({tag, "_ff"}, 32'(first_fail), 0);
        chk({tag, "_ffv"}, 32'(first_fail_vld), 0);
        chk({tag, "_cap"}, 32'(captured), 0);
    endtask

    task automatic do_run(input logic [15:0] t, input int bad_pos,
                          input logic [3:0] bad_vec, input int stop_at,
                          input bit rnd);
        int n;
        tab = t;
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_done_low", 32'(done), 0);
        chk("restart_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                vec_valid = 1'b0;
                vec = 4'($urandom);
                start = rnd && ($urandom_range(0, 4) == 0);
                cycle();
            end
            start = 1'b0;
            vec_valid = 1'b1;
            vec = (i == bad_pos) ? bad_vec : 4'(i);
            n = 0;
            while (!vec_ready && n < 20) begin cycle(); n++; end
            chk("vec_ready_wait", 32'(vec_ready), 1);
            if (!vec_ready) begin vec_valid = 1'b0; return; end
            start = rnd && ($urandom_range(0, 3) == 0);
            cycle();
            start = 1'b0;
            if (i == bad_pos || i == stop_at) begin
                vec_valid = 1'b0;
                return;
            end
            n = 0;
            while (!vec_ready && !done && n < 20) begin
                vec_valid = rnd ? 1'($urandom) : 1'b0;
                start = rnd && ($urandom_range(0, 3) == 0);
                cycle();
                n++;
            end
            vec_valid = 1'b0; start = 1'b0;
            chk("settle_wait", 32'(vec_ready | done), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bexp, mask, diff;
        int bp;
        logic [3:0] bv, ffexp;
        rst_n = 1'b0; start = 0; vec_valid = 0; vec = 0; tab = EXP_A;
        b_start = 0; b_vv = 0; b_vec = 0; b_g = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        chk_en = 1'b1;
        cycle(); cycle();

        do_run(EXP_A, 16, 4'd0, 16, 0);
        chk("good_done", 32'(done), 1);
        chk("good_pass", 32'(pass), 1);
        chk("good_mis", 32'(mismatch_cnt), 0);
        chk("good_cap", 32'(captured), 32'h0000A5C3);
        chk("good_ffv", 32'(first_fail_vld), 0);

        do_run(EXP_A ^ 16'h0220, 16, 4'd0, 16, 0);
        chk("bad59_mis", 32'(mismatch_cnt), 2);
        chk("bad59_ff", 32'(first_fail), 5);
        chk("bad59_ffv", 32'(first_fail_vld), 1);
        chk("bad59_pass", 32'(pass), 0);
        chk("bad59_cap", 32'(captured), 32'h0000A7E3);

        do_run(EXP_A, 16, 4'd0, 16, 0);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_pass", 32'(pass), 1);
        chk("rerun_mis", 32'(mismatch_cnt), 0);

        do_run(EXP_A, 2, 4'd3, 16, 0);
        chk("seq_seq_err", 32'(seq_err), 1);
        chk("seq_done", 32'(done), 1);
        chk("seq_cap", 32'(captured), 32'h00000003);
        chk("seq_pass", 32'(pass), 0);
        chk("seq_busy", 32'(busy), 0);

        do_run(EXP_A, 16, 4'd0, 7, 0);
        cycle();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        model_reset();
        cycle();
        rst_n = 1'b1;
        vec_valid = 1'b1; vec = 4'd0;
        repeat (4) cycle();
        chk("postrst_ready", 32'(vec_ready), 0);
        chk("postrst_busy", 32'(busy), 0);
        vec_valid = 1'b0;

        for (int r = 0; r < 24; r++) begin
            mask = 16'($urandom & $urandom & $urandom);
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
            bv = 4'(bp + int'($urandom_range(1, 15)));
            do_run(EXP_A ^ mask, bp, bv, 16, 1);
            if (bp == 16) begin
                chk("rnd_cap", 32'(captured), 32'(EXP_A ^ mask));
                chk("rnd_mis", 32'(mismatch_cnt), 32'($countones(mask)));
            end else begin
                chk("rnd_seq_cap", 32'(captured),
                    32'((EXP_A ^ mask) & 16'((32'd1 << bp) - 1)));
            end
        end

        b_start = 1'b1; cycle(); b_start = 1'b0;
        bexp = 16'h0;
        for (int i = 0; i < 16; i++) begin
            int n, low;
            logic x;
            b_vv = 1'b1; b_vec = 4'(i); n = 0;
            while (!b_ready && n < 20) begin cycle(); n++; end
            chk("b_ready_wait", 32'(b_ready), 1);
            cycle();
            b_vv = 1'b0;
            x = 1'($urandom);
            bexp[i] = x;
            low = 0;
            for (int k = 0; k < 3; k++) begin
                if (!b_ready) low++;
                b_g = (k == 1) ? ~x : x;
                cycle();
            end
            b_g = ~x;
            chk("b_ready_low_cycles", 32'(low), 3);
            chk("b_ready_back", 32'(b_ready | b_done), 1);
        end
        diff = bexp ^ EXP_A;
        ffexp = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) ffexp = 4'(i);
        chk("b_done", 32'(b_done), 1);
        chk("b_busy", 32'(b_busy), 0);
        chk("b_cap", 32'(b_cap), 32'(bexp));
        chk("b_mis", 32'(b_mis), 32'($countones(diff)));
        chk("b_pass", 32'(b_pass), 32'(diff == 16'h0));
        chk("b_ffv", 32'(b_ffv), 32'(diff != 16'h0));
        chk("b_ff", 32'(b_ff), 32'(ffexp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter EXPECTED, default 16'h0000, golden 4-input truth table; bit i is the expected output for vector i.
REQ-002 SHALL have parameter SETTLE, default 2, the number of clocks from vector acceptance to output sampling; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a check run.
REQ-006 SHALL have port vec_valid  input  1  the DUT-driving side has a vector on vec.
REQ-007 SHALL have port vec  input  4  applied vector {A,B,C,D}, with A as MSB.
REQ-008 SHALL have port vec_ready  output  1  the checker can accept a vector.
REQ-009 SHALL have port g_in  input  1  DUT output G under test.
REQ-010 SHALL have port busy  output  1  a run is in progress.
REQ-011 SHALL have port done  output  1  the run has finished; results are valid.
REQ-012 SHALL have port pass  output  1  the run had no mismatch and no sequence error.
REQ-013 SHALL have port seq_err  output  1  an out-of-order vector aborted the run.
REQ-014 SHALL have port mismatch_cnt  output  5  number of mismatching vectors, 0..16.
REQ-015 SHALL have port first_fail  output  4  index of the first mismatching vector.
REQ-016 SHALL have port first_fail_vld  output  1  first_fail holds a valid index.
REQ-017 SHALL have port captured  output  16  observed truth table; bit i is G sampled for vector i.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_VEC, SETTLE and DONE.
REQ-019 SHALL, in IDLE, move on start=1 to WAIT_VEC at the next edge, clear idx, captured, mismatch_cnt, first_fail, first_fail_vld, seq_err and pass, and set busy=1.
REQ-020 SHALL drive vec_ready=1 only in WAIT_VEC; acceptance occurs at an edge where vec_valid=1 and vec_ready=1.
REQ-021 SHALL, on acceptance with vec==idx, go to SETTLE and load a settle counter with SETTLE-1.
REQ-022 SHALL, on acceptance with vec!=idx, go to DONE, set seq_err=1, pass=0, done=1 and busy=0, with captured left unchanged.
REQ-023 SHALL, in SETTLE, decrement the counter each edge and sample g_in at the edge where the counter is 0, i.e. exactly SETTLE edges after the accepting edge.
REQ-024 SHALL, at the sample edge, write captured[idx]=g_in; if g_in!=EXPECTED[idx], increment mismatch_cnt and, when first_fail_vld=0, load first_fail=idx and set first_fail_vld=1.
REQ-025 SHALL, at the sample edge with idx<15, increment idx and return to WAIT_VEC, so vec_ready is high the following cycle.
REQ-026 SHALL, at the sample edge with idx==15, enter DONE with done=1, busy=0 and pass=(final mismatch_cnt==0), with the 16th comparison included.
REQ-027 SHALL ignore vec_valid in IDLE, SETTLE and DONE, and ignore start in WAIT_VEC and SETTLE.
REQ-028 SHALL, on start=1 in DONE, clear all results, deassert done and re-enter WAIT_VEC, as from IDLE.
REQ-029 SHALL hold all result outputs stable in DONE until restart or reset.
REQ-030 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-031 SHALL, on rst_n=0, immediately go to IDLE with vec_ready=0, busy=0, done=0, pass=0, seq_err=0, mismatch_cnt=0, first_fail=0, first_fail_vld=0 and captured=16'h0000, with idx and the settle counter at 0.
REQ-032 SHALL, when reset is asserted mid-run, discard the run; after release the block stays in IDLE until start.

Verification
REQ-033 SHALL be verified: EXPECTED=16'hA5C3, SETTLE=2, DUT truth table equal to EXPECTED, vectors 0..15 in order -> done=1, pass=1, mismatch_cnt=0, captured=16'hA5C3, first_fail_vld=0.
REQ-034 SHALL be verified: the same run with the DUT output at vectors 5 and 9 inverted -> mismatch_cnt=2, first_fail=5, first_fail_vld=1, pass=0, captured=16'hA7E3.
REQ-035 SHALL be verified: vectors 0,1,3 applied -> seq_err=1 and done=1 at the edge accepting 3, captured bits [1:0] only written, pass=0.
REQ-036 SHALL be verified: SETTLE=3, g_in toggled 1 and 2 cycles after acceptance -> the value at the 3rd edge is captured, and vec_ready is low for exactly 3 cycles per vector.
REQ-037 SHALL be verified: rst_n pulsed low after vector 7 is accepted -> all outputs at reset values at once, and vec_valid is ignored until a new start.
REQ-038 SHALL be verified: start in DONE after a failing run, followed by a passing run -> done drops, then done=1, pass=1, mismatch_cnt=0.
